// File: rtl/chip8_memory.sv
// 4 KiB byte-wide CHIP-8 memory: registered read port, font preload, then a valid/ready program loader.
// Define C8_FONT_EN to preload the 80-byte hex font at 0x000 before loading starts at PROG_BASE.
module chip8_memory #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int PROG_BASE  = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] d,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_valid,
  input  logic                  ld_last,
  output logic                  ld_ready,
  output logic                  loaded,
  output logic                  overflow,
  output logic [1:0]            dbg_state
);

  // Load handshake: a byte moves on a rising edge where ld_valid and ld_ready
  // are both high; ld_data/ld_last are only meaningful while ld_valid is high.

  typedef enum logic [1:0] {
    ST_FONT = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(PROG_BASE);
  localparam logic [ADDR_WIDTH-1:0] TOP_ADDR  = {ADDR_WIDTH{1'b1}};

`ifdef C8_FONT_EN
  localparam logic [ADDR_WIDTH-1:0] FONT_LAST = ADDR_WIDTH'(79);
  localparam logic [7:0] FONT [0:79] = '{
    8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
    8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
    8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
  };
  localparam state_t RST_STATE = ST_FONT;
  localparam logic [ADDR_WIDTH-1:0] RST_WADDR = '0;
  localparam logic RST_READY = 1'b0;
`else
  localparam state_t RST_STATE = ST_LOAD;
  localparam logic [ADDR_WIDTH-1:0] RST_WADDR = BASE_ADDR;
  localparam logic RST_READY = 1'b1;
`endif

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
  state_t                state;
  logic [ADDR_WIDTH-1:0] waddr;
  logic                  xfer;
  logic                  we;
  logic [DATA_WIDTH-1:0] wdata;

  always_comb begin
    xfer  = ld_valid && ld_ready && (state == ST_LOAD);
    we    = 1'b0;
    wdata = ld_data;
`ifdef C8_FONT_EN
    if (state == ST_FONT) begin
      we    = 1'b1;
      wdata = DATA_WIDTH'(FONT[waddr[6:0]]);
    end
`endif
    if (xfer) we = 1'b1;
    if (rst)  we = 1'b0;
  end

  // Array has no reset so contents survive a mid-operation reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read-before-write falls out of non-blocking semantics on the shared array.
  always_ff @(posedge clk) begin
    if (rst) d <= '0;
    else     d <= mem[raddr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RST_STATE;
      waddr    <= RST_WADDR;
      ld_ready <= RST_READY;
      loaded   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        ST_FONT: begin
`ifdef C8_FONT_EN
          if (waddr == FONT_LAST) begin
            waddr    <= BASE_ADDR;
            state    <= ST_LOAD;
            ld_ready <= 1'b1;
          end else begin
            waddr <= waddr + 1'b1;
          end
`else
          state    <= ST_LOAD;
          waddr    <= BASE_ADDR;
          ld_ready <= 1'b1;
`endif
        end
        ST_LOAD: begin
          if (xfer) begin
            if (ld_last) begin
              state    <= ST_DONE;
              loaded   <= 1'b1;
              ld_ready <= 1'b0;
            end else if (waddr == TOP_ADDR) begin
              // Stop at the top instead of wrapping onto the font.
              state    <= ST_DONE;
              loaded   <= 1'b1;
              overflow <= 1'b1;
              ld_ready <= 1'b0;
            end else begin
              waddr <= waddr + 1'b1;
            end
          end
        end
        default: begin
          ld_ready <= 1'b0;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule
